// File: rtl/snake_pkg.sv
// Shared constants for the snake engine: directions, colours, FSM states.
// The optional SNAKE_WRAP_EN build lets the head wrap across grid edges.
package snake_pkg;

  localparam logic [1:0] DIR_R = 2'd0;
  localparam logic [1:0] DIR_U = 2'd1;
  localparam logic [1:0] DIR_L = 2'd2;
  localparam logic [1:0] DIR_D = 2'd3;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;
  localparam logic [2:0] RED   = 3'b100;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef logic [3:0] state_t;

  localparam state_t S_INIT  = 4'd0;
  localparam state_t S_IDLE  = 4'd1;
  localparam state_t S_MOVE  = 4'd2;
  localparam state_t S_SCAN  = 4'd3;
  localparam state_t S_ERASE = 4'd4;
  localparam state_t S_HEAD  = 4'd5;
  localparam state_t S_FOOD  = 4'd6;
  localparam state_t S_DRAWF = 4'd7;
  localparam state_t S_DEAD  = 4'd8;

  function automatic logic is_reverse(
    input logic [1:0] a,
    input logic [1:0] b
  );
    return (a ^ b) == 2'd2;
  endfunction

endpackage

// File: rtl/snake_lfsr.sv
// Free-running 16-bit Galois LFSR (taps 16,14,13,11) for food placement.
// Steps every clock; reseeds on synchronous reset.
module snake_lfsr
  import snake_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] value
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) lfsr_d = lfsr_d ^ 16'hB400;
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;

endmodule

// File: rtl/snake_engine.sv
// Snake game engine: body ring buffer, move FSM and pixel plot stream.
// Define SNAKE_WRAP_EN to wrap the head at grid edges instead of dying.
module snake_engine
  import snake_pkg::*;
#(
  parameter int GRID_W    = 160,
  parameter int GRID_H    = 120,
  parameter int MAX_LEN   = 256,
  parameter int START_LEN = 4,
  parameter int TICK_DIV  = 6666666
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dir_valid,
  input  logic [1:0]                 dir,
  output logic [7:0]                 pix_x,
  output logic [6:0]                 pix_y,
  output logic [2:0]                 pix_colour,
  output logic                       pix_plot,
  output logic [7:0]                 score,
  output logic [$clog2(MAX_LEN):0]   length,
  output logic                       game_over
);

  localparam int PW = $clog2(MAX_LEN);
  localparam int LW = PW + 1;
  localparam logic [8:0] GW9 = 9'(GRID_W);
  localparam logic [7:0] GH8 = 8'(GRID_H);
  localparam logic [LW-1:0] START_L = LW'(START_LEN);
  localparam logic [LW-1:0] FULL_L = LW'(MAX_LEN);
  localparam logic [31:0] TICK_TOP = 32'(TICK_DIV - 1);

  logic [7:0]    bx_q [MAX_LEN];
  logic [6:0]    by_q [MAX_LEN];
  logic [PW-1:0] head_q, tail_q, scan_q;
  logic [LW-1:0] len_q, cnt_q;
  state_t        state_q, state_d;
  logic [1:0]    dir_q, ndir_q;
  logic [7:0]    cx_q, fx_q, px_q;
  logic [6:0]    cy_q, fy_q, py_q;
  logic [2:0]    pc_q;
  logic          plot_q, grow_q, tick_q, over_q;
  logic [7:0]    score_q;
  logic [31:0]   tcnt_q;

  logic [15:0] lfsr_v;
  logic        lfsr_unused;
  logic [7:0]  hx, cand_x;
  logic [6:0]  hy, cand_y;
  logic [8:0]  nx;
  logic [7:0]  ny;
  logic        die_edge, hit, scan_last, food_ok;

  snake_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .value (lfsr_v)
  );

  assign lfsr_unused = lfsr_v[15];

  always_comb begin
    hx = bx_q[head_q];
    hy = by_q[head_q];
    nx = {1'b0, hx};
    ny = {1'b0, hy};
    unique case (ndir_q)
      DIR_R: nx = nx + 9'd1;
      DIR_L: nx = nx - 9'd1;
      DIR_U: ny = ny - 8'd1;
      DIR_D: ny = ny + 8'd1;
    endcase
`ifdef SNAKE_WRAP_EN
    if (nx == 9'h1FF)   nx = GW9 - 9'd1;
    else if (nx == GW9) nx = 9'd0;
    if (ny == 8'hFF)    ny = GH8 - 8'd1;
    else if (ny == GH8) ny = 8'd0;
    die_edge = 1'b0;
`else
    die_edge = (nx >= GW9) || (ny >= GH8);
`endif
    cand_x = nx[7:0];
    cand_y = ny[6:0];

    // Tail slot is vacated this move unless growing, so skip it.
    hit = (bx_q[scan_q] == cx_q) && (by_q[scan_q] == cy_q)
       && !((cnt_q == '0) && !grow_q);
    scan_last = (cnt_q == len_q - 1'b1);
    food_ok = ({1'b0, lfsr_v[7:0]} < GW9)
           && ({1'b0, lfsr_v[14:8]} < GH8)
           && !((lfsr_v[7:0] == cx_q) && (lfsr_v[14:8] == cy_q));

    state_d = state_q;
    unique case (state_q)
      S_INIT:  if (cnt_q == START_L) state_d = S_IDLE;
      S_IDLE:  if (tick_q) state_d = S_MOVE;
      S_MOVE:  state_d = die_edge ? S_DEAD : S_SCAN;
      S_SCAN: begin
        if (hit)            state_d = S_DEAD;
        else if (scan_last) state_d = S_ERASE;
      end
      S_ERASE: state_d = S_HEAD;
      S_HEAD:  state_d = S_FOOD;
      S_FOOD:  if (!grow_q || food_ok) state_d = S_DRAWF;
      S_DRAWF: state_d = S_IDLE;
      default: state_d = S_DEAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT;
      head_q  <= PW'(START_LEN - 1);
      tail_q  <= '0;
      scan_q  <= '0;
      len_q   <= START_L;
      cnt_q   <= '0;
      dir_q   <= DIR_R;
      ndir_q  <= DIR_R;
      cx_q    <= '0;
      cy_q    <= '0;
      fx_q    <= 8'(GRID_W / 4);
      fy_q    <= 7'(GRID_H / 4);
      px_q    <= '0;
      py_q    <= '0;
      pc_q    <= BLACK;
      plot_q  <= 1'b0;
      grow_q  <= 1'b0;
      tick_q  <= 1'b0;
      over_q  <= 1'b0;
      score_q <= '0;
      tcnt_q  <= '0;
      for (int i = 0; i < START_LEN; i++) begin
        bx_q[i] <= 8'(GRID_W / 2 - START_LEN + 1 + i);
        by_q[i] <= 7'(GRID_H / 2);
      end
    end else begin
      state_q <= state_d;
      plot_q  <= 1'b0;

      tcnt_q <= (tcnt_q == TICK_TOP) ? '0 : tcnt_q + 1;
      if (tcnt_q == TICK_TOP)
        tick_q <= 1'b1;
      else if (state_q == S_IDLE && tick_q)
        tick_q <= 1'b0;

      if (dir_valid && state_q != S_DEAD
          && !is_reverse(dir, dir_q))
        ndir_q <= dir;

      unique case (state_q)
        S_INIT: begin
          plot_q <= 1'b1;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q < START_L) begin
            px_q <= bx_q[head_q - cnt_q[PW-1:0]];
            py_q <= by_q[head_q - cnt_q[PW-1:0]];
            pc_q <= WHITE;
          end else begin
            px_q <= fx_q;
            py_q <= fy_q;
            pc_q <= RED;
          end
        end
        S_MOVE: begin
          dir_q  <= ndir_q;
          cx_q   <= cand_x;
          cy_q   <= cand_y;
          grow_q <= (cand_x == fx_q) && (cand_y == fy_q);
          cnt_q  <= '0;
          scan_q <= tail_q;
        end
        S_SCAN: begin
          cnt_q  <= cnt_q + 1'b1;
          scan_q <= scan_q + 1'b1;
        end
        S_ERASE: begin
          // A full buffer still drops its tail so the ring never overruns.
          if (!grow_q || len_q == FULL_L) begin
            plot_q <= 1'b1;
            px_q   <= bx_q[tail_q];
            py_q   <= by_q[tail_q];
            pc_q   <= BLACK;
            tail_q <= tail_q + 1'b1;
          end else begin
            len_q <= len_q + 1'b1;
          end
        end
        S_HEAD: begin
          bx_q[head_q + 1'b1] <= cx_q;
          by_q[head_q + 1'b1] <= cy_q;
          head_q <= head_q + 1'b1;
          plot_q <= 1'b1;
          px_q   <= cx_q;
          py_q   <= cy_q;
          pc_q   <= WHITE;
        end
        S_FOOD: begin
          if (grow_q && food_ok) begin
            fx_q <= lfsr_v[7:0];
            fy_q <= lfsr_v[14:8];
            if (score_q != 8'hFF) score_q <= score_q + 1'b1;
          end
        end
        S_DRAWF: begin
          if (grow_q) begin
            plot_q <= 1'b1;
            px_q   <= fx_q;
            py_q   <= fy_q;
            pc_q   <= RED;
          end
        end
        default: ;
      endcase

      if (state_d == S_DEAD && state_q != S_DEAD) begin
        over_q <= 1'b1;
        plot_q <= 1'b1;
        px_q   <= hx;
        py_q   <= hy;
        pc_q   <= RED;
      end
    end
  end

  assign pix_x      = px_q;
  assign pix_y      = py_q;
  assign pix_colour = pc_q;
  assign pix_plot   = plot_q;
  assign score      = score_q;
  assign length     = len_q;
  assign game_over  = over_q;

endmodule
